// File: rtl/commutation_seq.sv
// Six-step trapezoidal BLDC commutation sequencer.
// Open-loop step timer with break-before-make dead-time and brake.
module commutation_seq #(
  parameter int PERIOD_W    = 16,
  parameter int DEAD_CYCLES = 4,
  parameter int MIN_PERIOD  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ena_i,
  input  logic                dir_i,
  input  logic                brake_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [5:0]          status_o,
  output logic [2:0]          step_o,
  output logic                comm_o,
  output logic                running_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    DEAD,
    BRAKE_DT,
    BRAKE
  } state_t;

  localparam bit HAS_DEAD = DEAD_CYCLES > 0;
  localparam logic [PERIOD_W-1:0] MIN_P =
    PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DEAD_LAST =
    PERIOD_W'(HAS_DEAD ? DEAD_CYCLES - 1 : 0);
  localparam logic [5:0] BRAKE_PAT = 6'b010101;

  state_t              state;
  state_t              state_n;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_n;
  logic [PERIOD_W-1:0] per;
  logic [PERIOD_W-1:0] per_n;
  logic [PERIOD_W-1:0] per_in;
  logic [2:0]          step;
  logic [2:0]          step_n;
  logic [2:0]          step_adv;
  logic [5:0]          status_n;
  logic                comm_n;
  logic                running_n;
  logic                drive_last;
  logic                dead_last;

  function automatic logic [5:0] pattern(
    input logic [2:0] s
  );
    logic [5:0] p;
    case (s)
      3'd0:    p = 6'b100100;
      3'd1:    p = 6'b100001;
      3'd2:    p = 6'b001001;
      3'd3:    p = 6'b011000;
      3'd4:    p = 6'b010010;
      3'd5:    p = 6'b000110;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  assign per_in = (period_i < MIN_P) ? MIN_P : period_i;

  assign step_adv = dir_i
    ? ((step == 3'd0) ? 3'd5 : step - 3'd1)
    : ((step == 3'd5) ? 3'd0 : step + 3'd1);

  assign drive_last = cnt == per - PERIOD_W'(1);
  assign dead_last  = cnt == DEAD_LAST;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per;
    step_n  = step;
    comm_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (brake_i) begin
          state_n = HAS_DEAD ? BRAKE_DT : BRAKE;
          cnt_n   = '0;
        end else if (ena_i) begin
          state_n = DRIVE;
          step_n  = 3'd0;
          per_n   = per_in;
          cnt_n   = '0;
          comm_n  = 1'b1;
        end
      end
      DRIVE: begin
        if (brake_i) begin
          state_n = HAS_DEAD ? BRAKE_DT : BRAKE;
          cnt_n   = '0;
        end else if (!ena_i) begin
          state_n = IDLE;
          step_n  = 3'd0;
          cnt_n   = '0;
        end else if (drive_last && HAS_DEAD) begin
          state_n = DEAD;
          cnt_n   = '0;
        end else if (drive_last) begin
          step_n  = step_adv;
          per_n   = per_in;
          cnt_n   = '0;
          comm_n  = 1'b1;
        end else begin
          cnt_n = cnt + PERIOD_W'(1);
        end
      end
      DEAD: begin
        if (brake_i) begin
          state_n = BRAKE_DT;
          cnt_n   = '0;
        end else if (!ena_i) begin
          state_n = IDLE;
          step_n  = 3'd0;
          cnt_n   = '0;
        end else if (dead_last) begin
          state_n = DRIVE;
          step_n  = step_adv;
          per_n   = per_in;
          cnt_n   = '0;
          comm_n  = 1'b1;
        end else begin
          cnt_n = cnt + PERIOD_W'(1);
        end
      end
      BRAKE_DT: begin
        if (!brake_i) begin
          state_n = IDLE;
          step_n  = 3'd0;
          cnt_n   = '0;
        end else if (dead_last) begin
          state_n = BRAKE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + PERIOD_W'(1);
        end
      end
      BRAKE: begin
        if (!brake_i) begin
          state_n = IDLE;
          step_n  = 3'd0;
        end
      end
      default: begin
        state_n = IDLE;
        step_n  = 3'd0;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs decode from the next state so they register in step with it.
  always_comb begin
    status_n  = 6'b000000;
    running_n = 1'b0;
    unique case (1'b1)
      (state_n == DRIVE): begin
        status_n  = pattern(step_n);
        running_n = 1'b1;
      end
      (state_n == DEAD): begin
        running_n = 1'b1;
      end
      (state_n == BRAKE): begin
        status_n = BRAKE_PAT;
      end
      default: begin
        status_n  = 6'b000000;
        running_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      per       <= MIN_P;
      step      <= 3'd0;
      status_o  <= 6'b000000;
      comm_o    <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      per       <= per_n;
      step      <= step_n;
      status_o  <= status_n;
      comm_o    <= comm_n;
      running_o <= running_n;
    end
  end

  assign step_o = step;

endmodule

// File: tb/tb_commutation_seq.sv
// Bench for commutation_seq: vector table plus scripted
// multi-cycle sequences, checked through an expectation queue.
module tb_commutation_seq;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          dir = 1'b0;
  logic          brake = 1'b0;
  logic [PW-1:0] period = 16'd4;
  logic [5:0]    status;
  logic [2:0]    step;
  logic          comm;
  logic          running;

  commutation_seq #(
    .PERIOD_W   (PW),
    .DEAD_CYCLES(2),
    .MIN_PERIOD (2)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .ena_i    (ena),
    .dir_i    (dir),
    .brake_i  (brake),
    .period_i (period),
    .status_o (status),
    .step_o   (step),
    .comm_o   (comm),
    .running_o(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          e;
    logic          d;
    logic          b;
    logic [PW-1:0] p;
    logic [5:0]    st;
    logic [2:0]    sp;
    logic          cm;
    logic          rn;
    logic          cs;
  } vec_t;

  typedef struct {
    logic [5:0] st;
    logic [2:0] sp;
    logic       cm;
    logic       rn;
    logic       cs;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [5:0] pat [6] = '{
    6'b100100, 6'b100001, 6'b001001,
    6'b011000, 6'b010010, 6'b000110
  };

  task automatic check_legs(input string name);
    logic bad;
    bad = (status[5] & status[4]) |
          (status[3] & status[2]) |
          (status[1] & status[0]);
    if ($countones(status) > 2 &&
        !(status == 6'b010101 && !running))
      bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s legs: status=%b illegal", name, status);
    end
  endtask

  task automatic cyc(
    input logic r, input logic e,
    input logic d, input logic b,
    input logic [PW-1:0] p,
    input logic [5:0] st, input logic [2:0] sp,
    input logic cm, input logic rn, input logic cs,
    input string name
  );
    exp_t x;
    rst_n  = r;
    ena    = e;
    dir    = d;
    brake  = b;
    period = p;
    x = '{st, sp, cm, rn, cs, name};
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    n_chk++;
    if (status !== x.st || comm !== x.cm ||
        running !== x.rn ||
        (x.cs && step !== x.sp)) begin
      n_fail++;
      $display("FAIL %s: got st=%b sp=%0d cm=%b rn=%b, want st=%b sp=%0d cm=%b rn=%b",
               x.name, status, step, comm, running,
               x.st, x.sp, x.cm, x.rn);
    end
    check_legs(x.name);
  endtask

  // One full step: per DRIVE cycles then two dead cycles.
  task automatic run_step(
    input int s, input logic d, input int per,
    input logic [PW-1:0] p0, input logic [PW-1:0] p1,
    input string name
  );
    for (int c = 0; c < per; c++)
      cyc(1, 1, d, 0, (c == 0) ? p0 : p1,
          pat[s], 3'(s), c == 0, 1, 1, name);
    for (int c = 0; c < 2; c++)
      cyc(1, 1, d, 0, p1, 6'b000000, 3'(s), 0, 1, 1, name);
  endtask

  vec_t tbl[$];
  int   rev[7] = '{0, 5, 4, 3, 2, 1, 0};

  initial begin
    // reset held with ena high
    for (int i = 0; i < 3; i++)
      tbl.push_back('{0, 1, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1});
    // brake from idle: two dead cycles then brake pattern
    tbl.push_back('{1, 1, 0, 1, 16'd4, 6'b000000, 3'd0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 16'd4, 6'b000000, 3'd0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 16'd4, 6'b010101, 3'd0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 16'd4, 6'b010101, 3'd0, 0, 0, 0});
    // brake release goes to idle even with ena high
    tbl.push_back('{1, 1, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 0, 16'd4, 6'b100100, 3'd0, 1, 1, 1});
    tbl.push_back('{1, 1, 0, 0, 16'd4, 6'b100100, 3'd0, 0, 1, 1});
    // reset mid-drive
    tbl.push_back('{0, 1, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1});

    foreach (tbl[i])
      cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].b, tbl[i].p,
          tbl[i].st, tbl[i].sp, tbl[i].cm, tbl[i].rn,
          tbl[i].cs, "tbl");

    // forward run, wraps 5 -> 0
    for (int k = 0; k < 7; k++)
      run_step(k % 6, 0, 4, 16'd4, 16'd4, "fwd");
    // stop in the last drive cycle of step 1
    for (int c = 0; c < 4; c++)
      cyc(1, 1, 0, 0, 16'd4, pat[1], 3'd1, c == 0, 1, 1, "fwd1");
    cyc(1, 0, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1, "stop_last");
    cyc(1, 0, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1, "stop_idle");

    // stop mid-drive
    cyc(1, 1, 0, 0, 16'd4, pat[0], 3'd0, 1, 1, 1, "mid0");
    cyc(1, 1, 0, 0, 16'd4, pat[0], 3'd0, 0, 1, 1, "mid1");
    cyc(1, 0, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1, "stop_mid");

    // reverse run, then stop wins over the pending advance
    foreach (rev[k])
      run_step(rev[k], 1, 3, 16'd3, 16'd3, "rev");
    cyc(1, 0, 1, 0, 16'd3, 6'b000000, 3'd0, 0, 0, 1, "rev_stop");

    // clamp of period 0, then 4 -> 8 update mid-drive
    run_step(0, 0, 2, 16'd0, 16'd0, "clamp");
    run_step(1, 0, 4, 16'd4, 16'd8, "upd4");
    run_step(2, 0, 8, 16'd8, 16'd8, "upd8");
    cyc(1, 0, 0, 0, 16'd8, 6'b000000, 3'd0, 0, 0, 1, "upd_stop");

    // brake during step 2
    run_step(0, 0, 4, 16'd4, 16'd4, "brk_s0");
    run_step(1, 0, 4, 16'd4, 16'd4, "brk_s1");
    cyc(1, 1, 0, 0, 16'd4, pat[2], 3'd2, 1, 1, 1, "brk_s2");
    cyc(1, 1, 0, 0, 16'd4, pat[2], 3'd2, 0, 1, 1, "brk_s2");
    cyc(1, 1, 0, 1, 16'd4, 6'b000000, 3'd0, 0, 0, 0, "brk_dt");
    cyc(1, 1, 0, 1, 16'd4, 6'b000000, 3'd0, 0, 0, 0, "brk_dt");
    for (int c = 0; c < 3; c++)
      cyc(1, 1, 0, 1, 16'd4, 6'b010101, 3'd0, 0, 0, 0, "brk_hold");
    cyc(1, 0, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1, "brk_off");
    cyc(1, 0, 0, 0, 16'd4, 6'b000000, 3'd0, 0, 0, 1, "brk_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
